// File: rtl/regfile_mp_sb_pkg.sv
// regfile_mp_sb_pkg: shared state type and reset-value helper for the register file
package regfile_mp_sb_pkg;
  typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;
  function automatic logic [63:0] rf_reset_val(int idx, bit mode);
    return mode ? 64'(unsigned'(idx)) : 64'd0;
  endfunction
endpackage

// File: rtl/regfile_mp_sb_if.sv
// regfile_mp_sb_if: operand read, writeback, issue and clear-control bundle
interface regfile_mp_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_dest;
  logic                     clr_req;
  logic                     ready;
  logic                     clr_done;
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_dest, clr_req,
    input  rd_data, rd_busy, ready, clr_done
  );
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_dest, clr_req,
    output rd_data, rd_busy, ready, clr_done
  );
endinterface

// File: rtl/regfile_mp_sb_clear_fsm.sv
// regfile_mp_sb_clear_fsm: sweeps every entry back to its reset value, one per cycle
module regfile_mp_sb_clear_fsm
  import regfile_mp_sb_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              ready,
  output logic              clr_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);
  localparam int DEPTH = 2**ADDR_W;
  rf_state_t state;
  logic [ADDR_W-1:0] ptr;
  assign clr_we   = state == RF_CLEAR;
  assign clr_addr = ptr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= RF_IDLE;
      ptr      <= '0;
      ready    <= 1'b1;
      clr_done <= 1'b0;
    end else if (state == RF_IDLE) begin
      clr_done <= 1'b0;
      if (clr_req) begin
        state <= RF_CLEAR;
        ptr   <= '0;
        ready <= 1'b0;
      end
    end else begin
      ptr      <= ptr + 1'b1;
      // done is registered one entry early so it coincides with the last swept entry
      clr_done <= ptr == ADDR_W'(DEPTH-2);
      if (ptr == ADDR_W'(DEPTH-1)) begin
        state <= RF_IDLE;
        ready <= 1'b1;
      end
    end
endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with write bypass, busy scoreboard and bulk clear
module regfile_mp_sb
  import regfile_mp_sb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int RESET_MODE = 1,
  parameter int ZERO_REG   = 1
) (
  input logic           clk,
  input logic           rst,
  regfile_mp_sb_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0]        mem [DEPTH];
  logic [DEPTH-1:0]         busy;
  logic [NUM_WR-1:0]        wl;
  logic                     iss_ok, clr_we;
  logic [ADDR_W-1:0]        clr_addr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rbusy;
  logic [ADDR_W-1:0]        a;
  logic                     hit;
  function automatic logic [DATA_W-1:0] rst_val(int i);
    return DATA_W'(rf_reset_val(i, RESET_MODE != 0));
  endfunction
  regfile_mp_sb_clear_fsm #(.ADDR_W(ADDR_W)) u_clr (
    .clk(clk), .rst(rst), .clr_req(bus.clr_req), .ready(bus.ready),
    .clr_done(bus.clr_done), .clr_we(clr_we), .clr_addr(clr_addr)
  );
  // ready doubles as the idle qualifier, so writes and issues are dead during a sweep
  always_comb begin
    wl = '0;
    for (int j = 0; j < NUM_WR; j++)
      wl[j] = bus.ready && bus.wr_en[j] &&
              !(ZERO_REG != 0 && bus.wr_addr[j*ADDR_W +: ADDR_W] == '0);
    iss_ok = bus.ready && bus.iss_en && !(ZERO_REG != 0 && bus.iss_dest == '0);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= rst_val(i);
      busy <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++)
        if (wl[j]) begin
          mem[bus.wr_addr[j*ADDR_W +: ADDR_W]]  <= bus.wr_data[j*DATA_W +: DATA_W];
          busy[bus.wr_addr[j*ADDR_W +: ADDR_W]] <= 1'b0;
        end
      if (iss_ok) busy[bus.iss_dest] <= 1'b1;
      if (clr_we) begin
        mem[clr_addr]  <= rst_val(32'(clr_addr));
        busy[clr_addr] <= 1'b0;
      end
    end
  // later write ports overwrite earlier matches, giving highest-index priority
  always_comb begin
    rdata = '0;
    rbusy = '0;
    a     = '0;
    hit   = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      a   = bus.rd_addr[k*ADDR_W +: ADDR_W];
      hit = 1'b0;
      rdata[k*DATA_W +: DATA_W] = mem[a];
      for (int j = 0; j < NUM_WR; j++)
        if (wl[j] && bus.wr_addr[j*ADDR_W +: ADDR_W] == a) begin
          rdata[k*DATA_W +: DATA_W] = bus.wr_data[j*DATA_W +: DATA_W];
          hit = 1'b1;
        end
      rbusy[k] = busy[a] && !(hit && !(iss_ok && bus.iss_dest == a));
      if (ZERO_REG != 0 && a == '0) begin
        rdata[k*DATA_W +: DATA_W] = '0;
        rbusy[k] = 1'b0;
      end
    end
  end
  assign bus.rd_data = rdata;
  assign bus.rd_busy = rbusy;
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: directed and randomized checks of regfile_mp_sb against an array-level model
module tb_regfile_mp_sb;
  localparam int DW = 32, AW = 5, NR = 2, NW = 2, DEPTH = 32;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;
  regfile_mp_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();
  regfile_mp_sb #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .RESET_MODE(1), .ZERO_REG(1)
  ) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  int ncmp = 0, nfail = 0;
  logic [DW-1:0] m_mem [DEPTH];
  bit m_busy [DEPTH];
  int clr_left, cpos, done_at;
  logic seen_done;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = DW'(i);
      m_busy[i] = 0;
    end
    clr_left = 0;
    cpos     = 0;
  endtask
  function automatic logic [AW-1:0] waddr(int j);
    return bus.wr_addr[j*AW +: AW];
  endfunction
  function automatic logic [DW-1:0] wdata(int j);
    return bus.wr_data[j*DW +: DW];
  endfunction
  function automatic bit legal(int j);
    return clr_left == 0 && bus.wr_en[j] && waddr(j) != 0;
  endfunction
  task automatic check_outputs;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit b, hit, iss;
    for (int k = 0; k < NR; k++) begin
      a   = bus.rd_addr[k*AW +: AW];
      d   = m_mem[a];
      b   = m_busy[a];
      hit = 0;
      for (int j = 0; j < NW; j++)
        if (legal(j) && waddr(j) == a) begin
          d   = wdata(j);
          hit = 1;
        end
      iss = clr_left == 0 && bus.iss_en && bus.iss_dest == a && a != 0;
      if (hit && !iss) b = 0;
      if (a == 0) begin
        d = 0;
        b = 0;
      end
      chk($sformatf("rd_data%0d@%0d", k, a), bus.rd_data[k*DW +: DW], d);
      chk($sformatf("rd_busy%0d@%0d", k, a), bus.rd_busy[k], b);
    end
    chk("ready", bus.ready, clr_left == 0);
    chk("clr_done", bus.clr_done, clr_left == 1);
  endtask
  task automatic model_step;
    if (clr_left == 0) begin
      for (int j = 0; j < NW; j++)
        if (legal(j)) begin
          m_mem[waddr(j)]  = wdata(j);
          m_busy[waddr(j)] = 0;
        end
      if (bus.iss_en && bus.iss_dest != 0) m_busy[bus.iss_dest] = 1;
      if (bus.clr_req) begin
        clr_left = DEPTH;
        cpos     = 0;
      end
    end else begin
      m_mem[cpos]  = DW'(cpos);
      m_busy[cpos] = 0;
      cpos++;
      clr_left--;
    end
  endtask
  task automatic cycle;
    @(negedge clk);
    check_outputs();
    seen_done = bus.clr_done;
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic idle_inputs;
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.iss_en   = 0;
    bus.iss_dest = '0;
    bus.clr_req  = 0;
  endtask
  task automatic set_wr(int j, int a, logic [DW-1:0] d);
    bus.wr_en[j]            = 1;
    bus.wr_addr[j*AW +: AW] = AW'(a);
    bus.wr_data[j*DW +: DW] = d;
  endtask
  task automatic set_rd(int k, int a);
    bus.rd_addr[k*AW +: AW] = AW'(a);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.rd_addr = '0;
    idle_inputs();
    model_reset();
    set_rd(0, 7);
    set_rd(1, 0);
    #12;
    chk("rst_rd7_in_reset", bus.rd_data[0 +: DW], 7);
    @(posedge clk);
    #1 rst = 1;
    chk("rst_rd7", bus.rd_data[0 +: DW], 7);
    chk("rst_rd0", bus.rd_data[DW +: DW], 0);
    chk("rst_busy", bus.rd_busy, 0);
    chk("rst_ready", bus.ready, 1);
    chk("rst_clr_done", bus.clr_done, 0);
    for (int a = 0; a < DEPTH; a += 2) begin
      set_rd(0, a);
      set_rd(1, a + 1);
      cycle();
    end
    set_wr(0, 3, 32'hAAAA);
    set_wr(1, 3, 32'h5555);
    set_rd(0, 3);
    #1 chk("wr_prio_bypass", bus.rd_data[0 +: DW], 32'h5555);
    cycle();
    idle_inputs();
    #1 chk("wr_prio_stored", bus.rd_data[0 +: DW], 32'h5555);
    set_wr(0, 0, 32'hFFFF_FFFF);
    bus.iss_en   = 1;
    bus.iss_dest = '0;
    set_rd(0, 0);
    #1 chk("zero_bypass", bus.rd_data[0 +: DW], 0);
    cycle();
    idle_inputs();
    #1 chk("zero_stored", bus.rd_data[0 +: DW], 0);
    chk("zero_busy", bus.rd_busy[0], 0);
    bus.iss_en   = 1;
    bus.iss_dest = 5;
    set_rd(1, 5);
    cycle();
    idle_inputs();
    #1 chk("iss_busy", bus.rd_busy[1], 1);
    set_wr(1, 5, 32'hCAFE);
    #1 chk("wb_busy_bypass", bus.rd_busy[1], 0);
    chk("wb_data_bypass", bus.rd_data[DW +: DW], 32'hCAFE);
    cycle();
    idle_inputs();
    #1 chk("wb_busy_after", bus.rd_busy[1], 0);
    bus.iss_en   = 1;
    bus.iss_dest = 5;
    set_wr(0, 5, 32'hBEEF);
    cycle();
    idle_inputs();
    #1 chk("iss_wr_busy", bus.rd_busy[1], 1);
    chk("iss_wr_data", bus.rd_data[DW +: DW], 32'hBEEF);
    set_wr(0, 9, 32'h1234);
    cycle();
    idle_inputs();
    bus.clr_req = 1;
    set_rd(0, 9);
    cycle();
    #1 chk("clr_ready_low", bus.ready, 0);
    done_at = 0;
    for (int c = 1; c <= 40 && done_at == 0; c++) begin
      set_wr(0, 9, 32'hFFFF);
      bus.iss_en   = 1;
      bus.iss_dest = 9;
      bus.clr_req  = 1;
      set_rd(1, $urandom_range(0, 31));
      cycle();
      if (seen_done) done_at = c;
    end
    chk("clr_length", done_at, DEPTH);
    idle_inputs();
    #1 chk("clr_ready_back", bus.ready, 1);
    chk("clr_entry9", bus.rd_data[0 +: DW], 9);
    chk("clr_busy9", bus.rd_busy[0], 0);
    for (int n = 0; n < 400; n++) begin
      bus.wr_en = NW'($urandom);
      for (int j = 0; j < NW; j++) begin
        bus.wr_addr[j*AW +: AW] = AW'($urandom_range(0, (n % 2) ? 7 : 31));
        bus.wr_data[j*DW +: DW] = $urandom;
      end
      bus.iss_en   = ($urandom % 3) == 0;
      bus.iss_dest = AW'($urandom_range(0, 7));
      bus.clr_req  = $urandom_range(0, 60) == 0;
      for (int k = 0; k < NR; k++) set_rd(k, $urandom_range(0, (n % 3) ? 7 : 31));
      cycle();
    end
    idle_inputs();
    for (int n = 0; n < 40 && clr_left != 0; n++) cycle();
    set_wr(0, 12, 32'hDEAD);
    bus.iss_en   = 1;
    bus.iss_dest = 13;
    cycle();
    idle_inputs();
    bus.clr_req = 1;
    cycle();
    idle_inputs();
    repeat (10) cycle();
    #2 rst = 0;
    model_reset();
    #1 chk("abort_ready", bus.ready, 1);
    chk("abort_clr_done", bus.clr_done, 0);
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(0, a);
      set_rd(1, DEPTH - 1 - a);
      #1 chk($sformatf("abort_data%0d", a), bus.rd_data[0 +: DW], DW'(a));
      chk($sformatf("abort_busy%0d", a), bus.rd_busy, 0);
    end
    @(posedge clk);
    #1 rst = 1;
    set_rd(0, 12);
    set_rd(1, 13);
    repeat (3) cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
